stoch_arith_engine: RTL and testbench

STOCH_ARITH_ENGINE -- requirements
Module: stoch_arith_engine

---
 rtl/stoch_pkg.sv | 22 ++
 rtl/stoch_lfsr.sv | 21 ++
 rtl/stoch_arith_engine.sv | 127 ++++++++++++
 tb/tb_stoch_arith_engine.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic arithmetic engine.
package stoch_pkg;

    typedef enum logic [1:0] {
        OP_BMUL = 2'b00,
        OP_SADD = 2'b01,
        OP_SQR  = 2'b10,
        OP_UMUL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int LFSR_W = 31;
    localparam int TAP_HI = 30;
    localparam int TAP_LO = 27;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 31'd1349395;

endpackage

// File: rtl/stoch_lfsr.sv
// 31-bit Fibonacci LFSR that shifts left; advances only while en is high.
module stoch_lfsr
    import stoch_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [LFSR_W-1:0] lfsr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= {lfsr[LFSR_W-2:0], lfsr[TAP_HI] ^ lfsr[TAP_LO]};
        end
    end

endmodule

// File: rtl/stoch_arith_engine.sv
// Stochastic-computing arithmetic engine: one operation per 2^LOG2_LEN-cycle bitstream.
// Optional STOCH_ABORT_EN adds an abort input that cancels a running stream.
module stoch_arith_engine
    import stoch_pkg::*;
#(
    parameter int                WIDTH    = 9,
    parameter int                LOG2_LEN = 17,
    parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef STOCH_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t                state;
    state_t                state_next;
    op_t                   op_reg;
    logic [WIDTH-1:0]      a_reg;
    logic [WIDTH-1:0]      b_reg;
    logic [LFSR_W-1:0]     lfsr;
    logic [LOG2_LEN-1:0]   cyc;
    logic [LOG2_LEN:0]     ones;
    logic [LOG2_LEN:0]     ones_next;
    logic                  delay;
    logic                  sa;
    logic                  sb;
    logic                  sel;
    logic                  bit_out;
    logic                  last;
    logic                  unused_lfsr;

    // A full-length stream of ones overflows into the top bit; clamp it.
    function automatic logic [WIDTH-1:0] scale_ones(input logic [LOG2_LEN:0] cnt);
        if (cnt[LOG2_LEN]) begin
            return '1;
        end
        return cnt[LOG2_LEN-1 -: WIDTH];
    endfunction

    stoch_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == ST_RUN),
        .lfsr  (lfsr)
    );

    assign unused_lfsr = ^lfsr;

    assign sa   = (lfsr[WIDTH-1:0] < a_reg);
    assign sb   = (lfsr[WIDTH+11:12] < b_reg);
    assign sel  = lfsr[TAP_HI] ^ lfsr[11];
    assign last = (cyc == '1);

    always_comb begin
        bit_out = 1'b0;
        case (op_reg)
            OP_BMUL: bit_out = ~(sa ^ sb);
            OP_SADD: bit_out = sel ? sb : sa;
            OP_SQR:  bit_out = ~(sa ^ delay);
            OP_UMUL: bit_out = sa & sb;
            default: bit_out = 1'b0;
        endcase
    end

    assign ones_next = ones + (LOG2_LEN+1)'(bit_out);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN: begin
`ifdef STOCH_ABORT_EN
                if (abort) state_next = ST_IDLE;
                else
`endif
                if (last) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_reg <= OP_BMUL;
            a_reg  <= '0;
            b_reg  <= '0;
            cyc    <= '0;
            ones   <= '0;
            delay  <= 1'b0;
            result <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && start) begin
                op_reg <= op_t'(op);
                a_reg  <= a;
                b_reg  <= b;
                cyc    <= '0;
                ones   <= '0;
                delay  <= 1'b0;
            end
            if (state == ST_RUN) begin
                cyc   <= cyc + LOG2_LEN'(1);
                ones  <= ones_next;
                delay <= sa;
                // Checked against state_next so an abort on the final cycle leaves result alone.
                if (state_next == ST_DONE) begin
                    result <= scale_ones(ones_next);
                end
            end
        end
    end

endmodule

// File: tb/tb_stoch_arith_engine.sv
// Scoreboard bench for stoch_arith_engine with a behavioural bitstream model.
module tb_stoch_arith_engine;

    localparam int W = 9;
    localparam int L = 10;
    localparam int N = 1 << L;
    localparam int MASK = (1 << W) - 1;
    localparam logic [30:0] SEED_V = 31'd1349395;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
`ifdef STOCH_ABORT_EN
    logic         abort;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_q[$];
    int unsigned m_lfsr;
    int          last_exp = 0;
    int          first_res;

    stoch_arith_engine #(.WIDTH(W), .LOG2_LEN(L), .SEED(SEED_V)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
`ifdef STOCH_ABORT_EN
        .abort  (abort),
`endif
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Walks one whole stream using the stated rules for stream bits and counting.
    task automatic model_run(input int opv, input int av, input int bv, output int res);
        int unsigned x;
        int ones;
        bit sa, sb, sel, prev, o;
        x = m_lfsr;
        ones = 0;
        prev = 0;
        for (int i = 0; i < N; i++) begin
            sa  = (x & MASK) < av;
            sb  = ((x >> 12) & MASK) < bv;
            sel = (((x >> 30) ^ (x >> 11)) & 1) != 0;
            case (opv)
                0: o = (sa == sb);
                1: o = sel ? sb : sa;
                2: o = (sa == prev);
                default: o = sa && sb;
            endcase
            prev = sa;
            ones += int'(o);
            x = ((x << 1) & 32'h7FFF_FFFF) | (((x >> 30) ^ (x >> 27)) & 1);
        end
        m_lfsr = x;
        res = (ones >= N) ? MASK : (ones >> (L - W));
    endtask

    task automatic advance_model(input int n);
        for (int i = 0; i < n; i++)
            m_lfsr = ((m_lfsr << 1) & 32'h7FFF_FFFF) | (((m_lfsr >> 30) ^ (m_lfsr >> 27)) & 1);
    endtask

    task automatic issue_start(input int opv, input int av, input int bv);
        @(negedge clk);
        op = 2'(opv); a = W'(av); b = W'(bv); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); a = W'($urandom); b = W'($urandom);
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < N + 20; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", N + 20);
        end
    endtask

    task automatic run_op(input int opv, input int av, input int bv, input bit mid, input int fixed_exp);
        int e;
        bit ok;
        model_run(opv, av, bv, e);
        if (fixed_exp >= 0) e = fixed_exp;
        exp_q.push_back(e);
        issue_start(opv, av, bv);
        check("busy_after_start", int'(busy), 1);
        if (mid) begin
            repeat (200) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(ok);
        if (ok) begin
            last_exp = e;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            check("start_in_done_not_queued", int'(busy), 0);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse.
    initial begin : monitor
        int run_len;
        logic [W-1:0] prev_res;
        run_len = 0;
        prev_res = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (result !== prev_res && !done) begin
                    n_cmp++; n_bad++;
                    $display("FAIL result_changed_outside_done: got %0d expected %0d", result, prev_res);
                end
                if (busy) begin
                    run_len++;
                end else if (done) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_done: got result %0d expected no done", result);
                    end else begin
                        check("result", int'(result), exp_q.pop_front());
                    end
                    check("run_length", run_len, N);
                    run_len = 0;
                end else begin
                    run_len = 0;
                end
            end else begin
                run_len = 0;
            end
            prev_res = result;
        end
    end

    initial begin : stim
        int dummy;
        int cnt;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
`ifdef STOCH_ABORT_EN
        abort = 1'b0;
`endif
        m_lfsr = SEED_V;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_result", int'(result), 0);
        rst_n = 1'b1;

        model_run(0, 384, 384, first_res);
        m_lfsr = SEED_V;
        run_op(0, 384, 384, 1'b0, -1);
        run_op(0, 0, 0, 1'b1, 511);
        run_op(3, 0, 300, 1'b0, 0);
        run_op(1, 0, 0, 1'b0, 0);
        run_op(2, 0, int'($urandom_range(0, MASK)), 1'b0, 511);
        for (int i = 0; i < 8; i++)
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, MASK)),
                   int'($urandom_range(0, MASK)), 1'($urandom), -1);

        // Reset in the middle of a stream, then repeat the first run from a fresh LFSR.
        model_run(2, 200, 0, dummy);
        exp_q.push_back(dummy);
        issue_start(2, 200, 0);
        repeat (500) @(negedge clk);
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("midrun_reset_busy", int'(busy), 0);
        check("midrun_reset_done", int'(done), 0);
        check("midrun_reset_result", int'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_lfsr = SEED_V;
        run_op(0, 384, 384, 1'b0, first_res);

`ifdef STOCH_ABORT_EN
        model_run(3, 100, 100, dummy);
        m_lfsr = 0;
        exp_q.push_back(dummy);
        void'(exp_q.pop_back());
        cnt = 0;
        begin
            int unsigned saved;
            saved = m_lfsr;
        end
`endif
`ifdef STOCH_ABORT_EN
        // Abort after 100 RUN cycles; the model LFSR advances by the cycles actually run.
        m_lfsr = SEED_V;
        run_op(1, 77, 400, 1'b0, -1);
        begin
            int unsigned keep;
            keep = m_lfsr;
            issue_start(3, 100, 100);
            cnt = int'(busy);
            for (int i = 1; i < 100; i++) begin
                @(negedge clk);
                cnt += int'(busy);
            end
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("abort_busy", int'(busy), 0);
            check("abort_done", int'(done), 0);
            check("abort_result_held", int'(result), last_exp);
            m_lfsr = keep;
            advance_model(cnt);
        end
        run_op(0, 256, 128, 1'b0, -1);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
